// File: rtl/ltc_dac_serializer.sv
// SPI serializer for LTC2601 daisy chains and LTC2604 quad DACs.
// Fetches NUM_CH command words from a combinational-read memory and shifts them out MSB-first.
module ltc_dac_serializer #(
   parameter int NUM_CH  = 4,
   parameter int CLK_DIV = 1,
   parameter int CS_GAP  = 2,
   localparam int AW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic          clkin,
   input  logic          reset,
   input  logic          trig,
   input  logic          isQuadDac,
   input  logic [31:0]   word,
   output logic [AW-1:0] addr,
   output logic          sclk,
   output logic          csel,
   output logic          mosi,
   output logic          busy,
   output logic          flush,
   output logic          done
);

   localparam int BW = $clog2(NUM_CH * 32);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD, ST_GAP} state_t;

   state_t        r_state, w_state_next;
   logic [31:0]   r_data, w_data_next;
   logic [7:0]    r_div, w_div_next;
   logic [7:0]    r_gap, w_gap_next;
   logic [BW-1:0] r_bit, w_bit_next;
   logic [AW-1:0] r_chan, w_chan_next;
   logic [AW-1:0] r_addr, w_addr_next;
   logic          r_quad, w_quad_next;
   logic          r_pending, w_pending_next;
   logic          r_sclk, w_sclk_next;
   logic          r_csel, w_csel_next;
   logic          r_busy, w_busy_next;
   logic          r_flush, w_flush_next;
   logic          r_done, w_done_next;
   logic          w_last_bit;

   assign w_last_bit = r_quad ? (r_bit == BW'(23)) : (r_bit == BW'(NUM_CH * 32 - 1));

   always_comb begin
      w_state_next   = r_state;
      w_data_next    = r_data;
      w_div_next     = r_div;
      w_gap_next     = r_gap;
      w_bit_next     = r_bit;
      w_chan_next    = r_chan;
      w_addr_next    = r_addr;
      w_quad_next    = r_quad;
      w_pending_next = r_pending | (trig & (r_state != ST_IDLE));
      w_sclk_next    = r_sclk;
      w_csel_next    = r_csel;
      w_busy_next    = r_busy;
      w_flush_next   = 1'b0;
      w_done_next    = 1'b0;
      // addr moves to the next word once the current one has been consumed
      if (r_flush && (r_addr != AW'(NUM_CH - 1)))
         w_addr_next = r_addr + 1'b1;
      case (r_state)
         ST_IDLE: begin
            if (trig || r_pending) begin
               w_state_next   = ST_SHIFT;
               w_data_next    = word;
               w_quad_next    = isQuadDac;
               w_csel_next    = 1'b0;
               w_sclk_next    = 1'b0;
               w_busy_next    = 1'b1;
               w_flush_next   = 1'b1;
               w_div_next     = '0;
               w_bit_next     = '0;
               w_chan_next    = '0;
               w_pending_next = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (r_div == 8'(CLK_DIV - 1)) begin
               w_div_next = '0;
               if (!r_sclk) begin
                  w_sclk_next = 1'b1;
               end else begin
                  w_sclk_next = 1'b0;
                  if (w_last_bit) begin
                     w_state_next = ST_HOLD;
                  end else begin
                     w_bit_next = r_bit + 1'b1;
                     if (!r_quad && (r_bit[4:0] == 5'd31)) begin
                        w_data_next  = word;
                        w_flush_next = 1'b1;
                        w_chan_next  = r_chan + 1'b1;
                     end else begin
                        w_data_next = {r_data[30:0], 1'b0};
                     end
                  end
               end
            end else begin
               w_div_next = r_div + 1'b1;
            end
         end
         ST_HOLD: begin
            w_csel_next = 1'b1;
            if (r_quad && (r_chan != AW'(NUM_CH - 1))) begin
               w_state_next = ST_GAP;
               w_gap_next   = '0;
            end else begin
               w_state_next = ST_IDLE;
               w_busy_next  = 1'b0;
               w_done_next  = 1'b1;
               w_addr_next  = '0;
            end
         end
         ST_GAP: begin
            if (r_gap == 8'(CS_GAP - 1)) begin
               w_state_next = ST_SHIFT;
               w_csel_next  = 1'b0;
               w_data_next  = word;
               w_flush_next = 1'b1;
               w_chan_next  = r_chan + 1'b1;
               w_bit_next   = '0;
               w_div_next   = '0;
            end else begin
               w_gap_next = r_gap + 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_data    <= '0;
         r_div     <= '0;
         r_gap     <= '0;
         r_bit     <= '0;
         r_chan    <= '0;
         r_addr    <= '0;
         r_quad    <= 1'b0;
         r_pending <= 1'b0;
         r_sclk    <= 1'b0;
         r_csel    <= 1'b1;
         r_busy    <= 1'b0;
         r_flush   <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_data    <= w_data_next;
         r_div     <= w_div_next;
         r_gap     <= w_gap_next;
         r_bit     <= w_bit_next;
         r_chan    <= w_chan_next;
         r_addr    <= w_addr_next;
         r_quad    <= w_quad_next;
         r_pending <= w_pending_next;
         r_sclk    <= w_sclk_next;
         r_csel    <= w_csel_next;
         r_busy    <= w_busy_next;
         r_flush   <= w_flush_next;
         r_done    <= w_done_next;
      end
   end

   assign addr  = r_addr;
   assign sclk  = r_sclk;
   assign csel  = r_csel;
   assign busy  = r_busy;
   assign flush = r_flush;
   assign done  = r_done;
   // mosi follows the frame MSB of the shift register, forced low when idle
   assign mosi  = r_busy & (r_quad ? r_data[23] : r_data[31]);

endmodule

// File: tb/tb_ltc_dac_serializer.sv
// Directed bench for ltc_dac_serializer: daisy, quad, slow SCLK, retrigger, reset abort, mode change.
module tb_ltc_dac_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, trig_a, trig_b, is_quad;
   logic [31:0] mem_a [0:3];
   logic [31:0] mem_b;
   logic [1:0]  addr_a;
   logic [0:0]  addr_b;
   logic [31:0] word_a, word_b;
   logic sclk_a, csel_a, mosi_a, busy_a, flush_a, done_a;
   logic sclk_b, csel_b, mosi_b, busy_b, flush_b, done_b;

   assign word_a = mem_a[addr_a];
   assign word_b = mem_b;

   ltc_dac_serializer #(.NUM_CH(4), .CLK_DIV(1), .CS_GAP(2)) dut_a (
      .clkin(clk), .reset(reset), .trig(trig_a), .isQuadDac(is_quad), .word(word_a),
      .addr(addr_a), .sclk(sclk_a), .csel(csel_a), .mosi(mosi_a), .busy(busy_a),
      .flush(flush_a), .done(done_a));

   ltc_dac_serializer #(.NUM_CH(1), .CLK_DIV(3), .CS_GAP(2)) dut_b (
      .clkin(clk), .reset(reset), .trig(trig_b), .isQuadDac(1'b0), .word(word_b),
      .addr(addr_b), .sclk(sclk_b), .csel(csel_b), .mosi(mosi_b), .busy(busy_b),
      .flush(flush_b), .done(done_b));

   int checks = 0;
   int failures = 0;

   // selected-DUT view used by the capture task
   bit   cap_sel = 1'b0;
   logic s_sclk, s_csel, s_mosi, s_busy, s_flush, s_done;
   int   s_addr;
   always_comb begin
      s_sclk = cap_sel ? sclk_b : sclk_a;
      s_csel = cap_sel ? csel_b : csel_a;
      s_mosi = cap_sel ? mosi_b : mosi_a;
      s_busy = cap_sel ? busy_b : busy_a;
      s_flush = cap_sel ? flush_b : flush_a;
      s_done = cap_sel ? done_b : done_a;
      s_addr = cap_sel ? int'(addr_b) : int'(addr_a);
   end

   int n_low, n_rise, stab_viol, phase_viol, max_addr;
   int low_runs[$], high_runs[$], flush_cyc[$], flush_addr[$], done_cyc[$];
   logic [511:0] cap_vec;
   logic snap_csel, snap_sclk, snap_mosi, snap_busy;
   int   snap_addr;

   // Trig at cycle 0, then record behaviour for cycles 1..ncyc.
   task automatic capture(input bit sel, input int ncyc, input int div, input int t1,
                          input int t2, input int t3, input int rst_at, input int flip_at);
      logic p_sclk, p_mosi, p_csel;
      int lo_run, hi_run, lo_len, hi_len;
      bit seen_low;
      n_low = 0; n_rise = 0; stab_viol = 0; phase_viol = 0; max_addr = 0;
      low_runs.delete(); high_runs.delete(); flush_cyc.delete(); flush_addr.delete();
      done_cyc.delete(); cap_vec = '0;
      p_sclk = 0; p_mosi = 0; p_csel = 1; lo_run = 0; hi_run = 0; lo_len = 0; hi_len = 0;
      seen_low = 0;
      @(negedge clk);
      cap_sel = sel;
      if (sel) trig_b = 1'b1; else trig_a = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         trig_a = 1'b0; trig_b = 1'b0; reset = 1'b0;
         if (!s_csel) begin
            n_low++;
            if (p_csel) begin
               if (seen_low) high_runs.push_back(hi_len);
               lo_len = 0;
            end
            lo_len++;
            seen_low = 1;
         end else begin
            if (!p_csel) begin
               low_runs.push_back(lo_len);
               hi_len = 0;
            end
            hi_len++;
         end
         if (s_sclk && !p_sclk) begin
            n_rise++;
            cap_vec = {cap_vec[510:0], s_mosi};
            if (s_mosi !== p_mosi) stab_viol++;
            if (lo_run != div) phase_viol++;
         end
         if (s_sclk && p_sclk && (s_mosi !== p_mosi)) stab_viol++;
         if (!s_sclk && p_sclk && (hi_run != div)) phase_viol++;
         if (s_sclk) begin
            hi_run++; lo_run = 0;
         end else begin
            hi_run = 0; lo_run = s_csel ? 0 : lo_run + 1;
         end
         if (s_flush) begin
            flush_cyc.push_back(c); flush_addr.push_back(s_addr);
         end
         if (s_done) done_cyc.push_back(c);
         if (s_addr > max_addr) max_addr = s_addr;
         if (rst_at > 0 && c == rst_at + 1) begin
            snap_csel = s_csel; snap_sclk = s_sclk; snap_mosi = s_mosi;
            snap_busy = s_busy; snap_addr = s_addr;
         end
         p_sclk = s_sclk; p_mosi = s_mosi; p_csel = s_csel;
         if (c == t1 || c == t2 || c == t3) begin
            if (sel) trig_b = 1'b1; else trig_a = 1'b1;
         end
         if (c == rst_at) reset = 1'b1;
         if (c == flip_at) is_quad = ~is_quad;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({csel_a, sclk_a, mosi_a, busy_a, flush_a, done_a} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=100000",
                  {csel_a, sclk_a, mosi_a, busy_a, flush_a, done_a});
      end
      checks++;
      if (addr_a !== 2'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", addr_a); end
      checks++;
      if ({csel_b, busy_b} !== 2'b10) begin
         failures++; $display("FAIL reset_b got=%b want=10", {csel_b, busy_b});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_daisy;
      logic [127:0] exp_bits;
      int exp_fl [4] = '{1, 65, 129, 193};
      int bad;
      mem_a[0] = 32'h00301111; mem_a[1] = 32'h00302222;
      mem_a[2] = 32'h00303333; mem_a[3] = 32'h00304444;
      exp_bits = {32'h00301111, 32'h00302222, 32'h00303333, 32'h00304444};
      is_quad = 1'b0;
      capture(0, 262, 1, 0, 0, 0, 0, 0);
      checks++;
      if (n_low != 257 || low_runs.size() != 1) begin
         failures++; $display("FAIL daisy_csel_low got=%0d runs=%0d want=257 runs=1", n_low, low_runs.size());
      end
      checks++;
      if (n_rise != 128) begin failures++; $display("FAIL daisy_rises got=%0d want=128", n_rise); end
      checks++;
      if (cap_vec[127:0] !== exp_bits) begin
         failures++; $display("FAIL daisy_bits got=%h want=%h", cap_vec[127:0], exp_bits);
      end
      bad = (flush_cyc.size() == 4) ? 0 : 1;
      if (bad == 0) foreach (exp_fl[i]) if (flush_cyc[i] != exp_fl[i] || flush_addr[i] != i) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL daisy_flush got=%p addr=%p want=1,65,129,193", flush_cyc, flush_addr); end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 258) begin
         failures++; $display("FAIL daisy_done got=%p want=258", done_cyc);
      end
      checks++;
      if (stab_viol != 0 || phase_viol != 0) begin
         failures++; $display("FAIL daisy_timing got=%0d/%0d want=0/0", stab_viol, phase_viol);
      end
      $display("test_daisy done");
   endtask

   task automatic test_quad;
      logic [95:0] exp_bits;
      int bad;
      mem_a[0] = 32'hAB3A5C01; mem_a[1] = 32'hCD3B6E02;
      mem_a[2] = 32'hEF3C7F03; mem_a[3] = 32'h123D8004;
      exp_bits = {24'h3A5C01, 24'h3B6E02, 24'h3C7F03, 24'h3D8004};
      is_quad = 1'b1;
      capture(0, 210, 1, 0, 0, 0, 0, 0);
      bad = (low_runs.size() == 4 && high_runs.size() == 3) ? 0 : 1;
      if (bad == 0) begin
         foreach (low_runs[i]) if (low_runs[i] != 49) bad++;
         foreach (high_runs[i]) if (high_runs[i] != 2) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL quad_windows low=%p high=%p want=4x49 3x2", low_runs, high_runs); end
      checks++;
      if (n_rise != 96 || cap_vec[95:0] !== exp_bits) begin
         failures++; $display("FAIL quad_bits got=%h n=%0d want=%h", cap_vec[95:0], n_rise, exp_bits);
      end
      checks++;
      if (flush_cyc.size() != 4 || flush_cyc[1] != 52 || flush_cyc[3] != 154 || flush_addr[3] != 3) begin
         failures++; $display("FAIL quad_flush got=%p want=1,52,103,154", flush_cyc);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 203) begin
         failures++; $display("FAIL quad_done got=%p want=203", done_cyc);
      end
      $display("test_quad done");
   endtask

   task automatic test_clkdiv3;
      mem_b = 32'hA5A5A5A5;
      capture(1, 200, 3, 0, 0, 0, 0, 0);
      checks++;
      if (n_low != 193) begin failures++; $display("FAIL div3_csel_low got=%0d want=193", n_low); end
      checks++;
      if (n_rise != 32 || cap_vec[31:0] !== 32'hA5A5A5A5) begin
         failures++; $display("FAIL div3_bits got=%h n=%0d want=a5a5a5a5", cap_vec[31:0], n_rise);
      end
      checks++;
      if (phase_viol != 0 || stab_viol != 0) begin
         failures++; $display("FAIL div3_timing phase=%0d stab=%0d want=0/0", phase_viol, stab_viol);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != 194) begin
         failures++; $display("FAIL div3_done got=%p want=194", done_cyc);
      end
      cap_sel = 1'b0;
      $display("test_clkdiv3 done");
   endtask

   task automatic test_back_to_back;
      logic [255:0] exp_bits;
      mem_a[0] = 32'h00301111; mem_a[1] = 32'h00302222;
      mem_a[2] = 32'h00303333; mem_a[3] = 32'h00304444;
      exp_bits = {2{32'h00301111, 32'h00302222, 32'h00303333, 32'h00304444}};
      is_quad = 1'b0;
      capture(0, 530, 1, 10, 50, 100, 0, 0);
      checks++;
      if (done_cyc.size() != 2 || done_cyc[0] != 258 || done_cyc[1] != 516) begin
         failures++; $display("FAIL retrig_done got=%p want=258,516", done_cyc);
      end
      checks++;
      if (low_runs.size() != 2 || high_runs.size() != 1 || high_runs[0] != 1) begin
         failures++; $display("FAIL retrig_frames low=%p high=%p want=2 frames gap 1", low_runs, high_runs);
      end
      checks++;
      if (cap_vec[255:0] !== exp_bits || n_rise != 256) begin
         failures++; $display("FAIL retrig_bits got=%h n=%0d", cap_vec[255:0], n_rise);
      end
      checks++;
      if (max_addr > 3 || flush_cyc.size() != 8) begin
         failures++; $display("FAIL retrig_addr max=%0d flushes=%0d want<=3/8", max_addr, flush_cyc.size());
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_abort;
      logic [95:0] exp_bits;
      mem_a[0] = 32'hAB3A5C01; mem_a[1] = 32'hCD3B6E02;
      mem_a[2] = 32'hEF3C7F03; mem_a[3] = 32'h123D8004;
      exp_bits = {24'h3A5C01, 24'h3B6E02, 24'h3C7F03, 24'h3D8004};
      is_quad = 1'b1;
      capture(0, 80, 1, 0, 0, 0, 72, 0);
      checks++;
      if ({snap_csel, snap_sclk, snap_mosi, snap_busy} !== 4'b1000 || snap_addr != 0) begin
         failures++; $display("FAIL abort_state got=%b addr=%0d want=1000 addr=0",
                              {snap_csel, snap_sclk, snap_mosi, snap_busy}, snap_addr);
      end
      checks++;
      if (done_cyc.size() != 0) begin failures++; $display("FAIL abort_no_done got=%p want=none", done_cyc); end
      capture(0, 210, 1, 0, 0, 0, 0, 0);
      checks++;
      if (cap_vec[95:0] !== exp_bits || done_cyc.size() != 1 || done_cyc[0] != 203) begin
         failures++; $display("FAIL abort_rerun got=%h done=%p want=%h done=203", cap_vec[95:0], done_cyc, exp_bits);
      end
      $display("test_reset_abort done");
   endtask

   task automatic test_mode_change;
      logic [127:0] exp_d;
      logic [95:0]  exp_q;
      mem_a[0] = 32'h00301111; mem_a[1] = 32'h00302222;
      mem_a[2] = 32'h00303333; mem_a[3] = 32'h00304444;
      exp_d = {32'h00301111, 32'h00302222, 32'h00303333, 32'h00304444};
      exp_q = {24'h301111, 24'h302222, 24'h303333, 24'h304444};
      is_quad = 1'b0;
      capture(0, 262, 1, 0, 0, 0, 0, 20);
      checks++;
      if (cap_vec[127:0] !== exp_d || done_cyc.size() != 1 || done_cyc[0] != 258) begin
         failures++; $display("FAIL mode_daisy got=%h done=%p want=%h done=258", cap_vec[127:0], done_cyc, exp_d);
      end
      capture(0, 210, 1, 0, 0, 0, 0, 0);
      checks++;
      if (cap_vec[95:0] !== exp_q || low_runs.size() != 4 || done_cyc.size() != 1 || done_cyc[0] != 203) begin
         failures++; $display("FAIL mode_quad got=%h runs=%0d done=%p want=%h", cap_vec[95:0], low_runs.size(), done_cyc, exp_q);
      end
      $display("test_mode_change done");
   endtask

   initial begin
      reset = 1'b1; trig_a = 1'b0; trig_b = 1'b0; is_quad = 1'b0;
      mem_b = 32'h0;
      for (int i = 0; i < 4; i++) mem_a[i] = 32'h0;
      test_reset;
      test_daisy;
      test_quad;
      test_clkdiv3;
      test_back_to_back;
      test_reset_abort;
      test_mode_change;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
